// File: rtl/voltage_stats_pkg.sv
// rtl/voltage_stats_pkg.sv - shared types and constants for the voltage window statistics block
package voltage_stats_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // Sliced down to DATA_W by users so one constant serves any sample width.
    localparam logic [63:0] MIN_INIT = '1;

    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } fsm_t;

endpackage

// File: rtl/window_accumulator.sv
// rtl/window_accumulator.sv - per-window sum/min/max datapath with EMPTY/FILL sequencing
module window_accumulator
    import voltage_stats_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int LOG2_WIN = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   sample_i,
    input  logic                valid_i,
    input  logic                clear_i,
    output logic                done_o,
    output logic [DATA_W-1:0]   done_avg_o,
    output logic [DATA_W-1:0]   done_min_o,
    output logic [DATA_W-1:0]   done_max_o,
    output logic [LOG2_WIN-1:0] fill_count_o
);

    localparam int ACC_W = DATA_W + LOG2_WIN;
    localparam logic [LOG2_WIN-1:0] FILL_LAST = '1;
    localparam logic [DATA_W-1:0]   MIN_RST   = MIN_INIT[DATA_W-1:0];

    fsm_t                state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [DATA_W-1:0]   min_q, min_d;
    logic [DATA_W-1:0]   max_q, max_d;
    logic [LOG2_WIN-1:0] fill_q, fill_d;

    logic [ACC_W-1:0]    sum;
    logic [DATA_W-1:0]   s_min;
    logic [DATA_W-1:0]   s_max;

    // Running values including the current sample; these are the final results on completion.
    assign sum   = acc_q + ACC_W'(sample_i);
    assign s_min = (sample_i < min_q) ? sample_i : min_q;
    assign s_max = (sample_i > max_q) ? sample_i : max_q;

    assign done_avg_o   = sum[ACC_W-1:LOG2_WIN];
    assign done_min_o   = s_min;
    assign done_max_o   = s_max;
    assign fill_count_o = fill_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        min_d   = min_q;
        max_d   = max_q;
        fill_d  = fill_q;
        done_o  = 1'b0;
        if (clear_i) begin
            state_d = EMPTY;
            acc_d   = '0;
            min_d   = MIN_RST;
            max_d   = '0;
            fill_d  = '0;
        end else if (valid_i) begin
            case (state_q)
                EMPTY: begin
                    state_d = FILL;
                    acc_d   = ACC_W'(sample_i);
                    min_d   = sample_i;
                    max_d   = sample_i;
                    fill_d  = LOG2_WIN'(1);
                end
                FILL: begin
                    if (fill_q == FILL_LAST) begin
                        done_o  = 1'b1;
                        state_d = EMPTY;
                        acc_d   = '0;
                        min_d   = MIN_RST;
                        max_d   = '0;
                        fill_d  = '0;
                    end else begin
                        acc_d   = sum;
                        min_d   = s_min;
                        max_d   = s_max;
                        fill_d  = fill_q + LOG2_WIN'(1);
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            min_q   <= MIN_RST;
            max_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            min_q   <= min_d;
            max_q   <= max_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: rtl/voltage_window_stats.sv
// rtl/voltage_window_stats.sv - windowed avg/min/max of a voltage stream with valid/ready result port
// Optional over-voltage alarm enabled by defining OVERVOLT_ALARM_EN.
module voltage_window_stats
    import voltage_stats_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int LOG2_WIN = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   sample_in,
    input  logic                sample_valid,
    input  logic                clear,
    output logic [DATA_W-1:0]   stats_avg,
    output logic [DATA_W-1:0]   stats_min,
    output logic [DATA_W-1:0]   stats_max,
    output logic                stats_valid,
    input  logic                stats_ready,
    output logic                overrun,
    output logic [LOG2_WIN-1:0] fill_count,
    input  logic [DATA_W-1:0]   alarm_thresh,
    output logic                alarm
);

    logic              done;
    logic [DATA_W-1:0] done_avg, done_min, done_max;

    logic [DATA_W-1:0] avg_q, avg_d;
    logic [DATA_W-1:0] min_q, min_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    window_accumulator #(
        .DATA_W   (DATA_W),
        .LOG2_WIN (LOG2_WIN)
    ) u_acc (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_i     (sample_in),
        .valid_i      (sample_valid),
        .clear_i      (clear),
        .done_o       (done),
        .done_avg_o   (done_avg),
        .done_min_o   (done_min),
        .done_max_o   (done_max),
        .fill_count_o (fill_count)
    );

    // A new result always wins; an unaccepted one being replaced marks overrun.
    always_comb begin
        avg_d     = avg_q;
        min_d     = min_q;
        max_d     = max_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && stats_ready) begin
            valid_d = 1'b0;
        end
        if (done) begin
            avg_d   = done_avg;
            min_d   = done_min;
            max_d   = done_max;
            valid_d = 1'b1;
            if (valid_q && !stats_ready) begin
                overrun_d = 1'b1;
            end
        end
        if (clear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_q     <= '0;
            min_q     <= '0;
            max_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            avg_q     <= avg_d;
            min_q     <= min_d;
            max_q     <= max_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign stats_avg   = avg_q;
    assign stats_min   = min_q;
    assign stats_max   = max_q;
    assign stats_valid = valid_q;
    assign overrun     = overrun_q;

`ifdef OVERVOLT_ALARM_EN
    logic alarm_q, alarm_d;

    always_comb begin
        alarm_d = alarm_q;
        if (clear) begin
            alarm_d = 1'b0;
        end else if (sample_valid && (sample_in > alarm_thresh)) begin
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`else
    logic [DATA_W-1:0] unused_thresh;
    assign unused_thresh = alarm_thresh;
    assign alarm         = 1'b0;
`endif

endmodule
